nbit_signmag_to_twos: RTL and testbench

Bit-serial converter from sign-magnitude to two's complement, WIDTH bits total (1 sign bit plus WIDTH-1 magnitude bits). It is the reverse of the ALU's two's-complement-to-magnitude path. It restores signed operands after magnitude-domain operations such as the shift/multiply paths. Processing is LSB-first at one bit per clock: bits are copied up to and including the first 1, then inverted when the sign is negative. It uses a start/busy/done handshake.

---
 rtl/nbit_signmag_to_twos.sv | 113 +++++++++++
 tb/tb_nbit_signmag_to_twos.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nbit_signmag_to_twos.sv
// Bit-serial sign-magnitude to two's-complement converter.
// The magnitude is walked LSB-first one bit per clock: bits are copied up to
// and including the first 1, and every later bit is inverted when the operand
// is negative. A start/busy/done handshake frames each conversion.
module nbit_signmag_to_twos #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-2:0] Mag,
    output logic [WIDTH-1:0] Com,
    output logic             busy,
    output logic             done,
    output logic             neg_zero
);

    // Counter needs to reach WIDTH-1 without wrapping; keep at least one bit.
    localparam int CNT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shiftReg_q, shiftReg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               negative_q, negative_d;
    logic               seenOne_q, seenOne_d;
    logic [WIDTH-1:0]   com_q, com_d;
    logic               negZero_q, negZero_d;
    logic               curBit;
    logic               outBit;

    // State and datapath registers; reset wins over everything and aborts a conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            result_q   <= '0;
            count_q    <= '0;
            negative_q <= 1'b0;
            seenOne_q  <= 1'b0;
            com_q      <= '0;
            negZero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            result_q   <= result_d;
            count_q    <= count_d;
            negative_q <= negative_d;
            seenOne_q  <= seenOne_d;
            com_q      <= com_d;
            negZero_q  <= negZero_d;
        end
    end

    // Next-state logic: latch operands in IDLE, process one bit per SHIFT cycle,
    // publish the result on the last SHIFT edge, then spend one cycle in DONE.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        result_d   = result_q;
        count_d    = count_q;
        negative_d = negative_q;
        seenOne_d  = seenOne_q;
        com_d      = com_q;
        negZero_d  = negZero_q;
        curBit     = shiftReg_q[0];
        outBit     = (negative_q & seenOne_q) ? ~shiftReg_q[0] : shiftReg_q[0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    shiftReg_d = {1'b0, Mag};
                    negative_d = sign;
                    result_d   = '0;
                    count_d    = '0;
                    seenOne_d  = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                result_d   = {outBit, result_q[WIDTH-1:1]};
                shiftReg_d = {1'b0, shiftReg_q[WIDTH-1:1]};
                seenOne_d  = seenOne_q | curBit;
                count_d    = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    state_d   = DONE;
                    com_d     = {outBit, result_q[WIDTH-1:1]};
                    negZero_d = negative_q & ~(seenOne_q | curBit);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Com      = com_q;
    assign neg_zero = negZero_q;
    assign busy     = (state_q == SHIFT) || (state_q == DONE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_nbit_signmag_to_twos.sv
// Self-checking bench for nbit_signmag_to_twos at WIDTH=5.
module tb_nbit_signmag_to_twos;

   localparam int WIDTH = 5;

   logic             clk;
   logic             rst;
   logic             start;
   logic             sign;
   logic [WIDTH-2:0] mag;
   logic [WIDTH-1:0] com;
   logic             busy;
   logic             done;
   logic             negZero;

   int totalChecks;
   int badChecks;
   logic [WIDTH-1:0] heldCom;

   typedef struct {
      logic             sign;
      logic [WIDTH-2:0] mag;
      logic [WIDTH-1:0] com;
      logic             nz;
   } vector_t;

   vector_t vectors [0:9];

   nbit_signmag_to_twos #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sign     (sign),
      .Mag      (mag),
      .Com      (com),
      .busy     (busy),
      .done     (done),
      .neg_zero (negZero)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Guard against a hung simulation.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [WIDTH-2:0] m);
      start = 1'b1;
      sign  = s;
      mag   = m;
      step();
      start = 1'b0;
      sign  = 1'($urandom);
      mag   = (WIDTH-1)'($urandom);
   endtask

   task automatic runConversion(input string name, input logic s, input logic [WIDTH-2:0] m,
                                input logic [WIDTH-1:0] expCom, input logic expNz);
      int latency;
      logic got;
      applyStimulus(s, m);
      checkOutput({name, "-busyRise"}, busy, 1);
      checkOutput({name, "-comHeld"}, com, heldCom);
      latency = 0;
      got = 1'b0;
      for (int c = 1; c <= 12 && !got; c++) begin
         step();
         if (done) begin
            got = 1'b1;
            latency = c;
         end
      end
      checkOutput({name, "-latency"}, latency, WIDTH);
      checkOutput({name, "-com"}, com, expCom);
      checkOutput({name, "-negZero"}, negZero, expNz);
      step();
      checkOutput({name, "-idleBusy"}, busy, 0);
      checkOutput({name, "-idleDone"}, done, 0);
      heldCom = expCom;
   endtask

   initial begin
      int doneCount;
      int doneCycles [$];
      logic [WIDTH-1:0] lastCom;
      logic sawIdle;

      totalChecks = 0;
      badChecks   = 0;
      heldCom     = '0;
      rst   = 1'b1;
      start = 1'b0;
      sign  = 1'b0;
      mag   = '0;

      vectors[0] = '{1'b0, 4'b0101, 5'b00101, 1'b0};
      vectors[1] = '{1'b1, 4'b0101, 5'b11011, 1'b0};
      vectors[2] = '{1'b1, 4'b1111, 5'b10001, 1'b0};
      vectors[3] = '{1'b1, 4'b0001, 5'b11111, 1'b0};
      vectors[4] = '{1'b1, 4'b0000, 5'b00000, 1'b1};
      vectors[5] = '{1'b0, 4'b0000, 5'b00000, 1'b0};
      vectors[6] = '{1'b0, 4'b1111, 5'b01111, 1'b0};
      vectors[7] = '{1'b1, 4'b1000, 5'b11000, 1'b0};
      vectors[8] = '{1'b1, 4'b0110, 5'b11010, 1'b0};
      vectors[9] = '{1'b1, 4'b1010, 5'b10110, 1'b0};

      // Reset for two cycles, then idle with outputs at zero.
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("resetCom", com, 0);
         checkOutput("resetBusy", busy, 0);
         checkOutput("resetDone", done, 0);
         checkOutput("resetNegZero", negZero, 0);
      end

      // Table-driven conversions.
      for (int i = 0; i < 10; i++) begin
         runConversion($sformatf("vec%0d", i), vectors[i].sign, vectors[i].mag,
                       vectors[i].com, vectors[i].nz);
      end

      // start during SHIFT and during DONE must be ignored.
      start = 1'b1;
      sign  = 1'b1;
      mag   = 4'b0011;
      step();
      start = 1'b0;
      doneCount = 0;
      lastCom = '0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (done) begin
            doneCount++;
            lastCom = com;
            start = 1'b1;
            sign  = 1'b0;
            mag   = 4'b0111;
         end else if (c == 2) begin
            start = 1'b1;
            sign  = 1'b0;
            mag   = 4'b0111;
         end else begin
            start = 1'b0;
         end
      end
      checkOutput("busyIgnoreDoneCount", doneCount, 1);
      checkOutput("busyIgnoreCom", lastCom, 5'b11101);
      checkOutput("busyIgnoreIdle", busy, 0);

      // start held high: one done every WIDTH+2 cycles.
      start = 1'b1;
      sign  = 1'b0;
      mag   = 4'b0001;
      for (int c = 0; c < 30; c++) begin
         step();
         if (done) doneCycles.push_back(c);
      end
      checkOutput("heldStartCount", doneCycles.size(), 4);
      if (doneCycles.size() >= 2) begin
         for (int i = 1; i < doneCycles.size(); i++) begin
            checkOutput($sformatf("heldStartInterval%0d", i), doneCycles[i] - doneCycles[i-1], WIDTH + 2);
         end
      end
      checkOutput("heldStartCom", com, 5'b00001);
      start = 1'b0;
      sawIdle = 1'b0;
      for (int c = 0; c < 12 && !sawIdle; c++) begin
         step();
         if (!busy) sawIdle = 1'b1;
      end
      checkOutput("heldStartDrain", sawIdle, 1);

      // Reset in the third SHIFT cycle aborts without a done pulse.
      start = 1'b1;
      sign  = 1'b1;
      mag   = 4'b0110;
      step();
      start = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      checkOutput("abortBusy", busy, 0);
      checkOutput("abortDone", done, 0);
      checkOutput("abortCom", com, 0);
      checkOutput("abortNegZero", negZero, 0);
      rst = 1'b0;
      doneCount = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (done) doneCount++;
      end
      checkOutput("abortNoDone", doneCount, 0);
      heldCom = '0;
      runConversion("afterAbort", 1'b1, 4'b0010, 5'b11110, 1'b0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
